// File: rtl/cpu15_wb_pkg.sv
// Shared writeback definitions: op encodings, controller state and default widths.
package cpu15_wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_RN_W   = 3;

    localparam logic [1:0] WB_OP_NOP  = 2'b00;
    localparam logic [1:0] WB_OP_ALU  = 2'b01;
    localparam logic [1:0] WB_OP_LOAD = 2'b10;
    localparam logic [1:0] WB_OP_LINK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_WRITE = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_load_timer.sv
// Load timeout counter: counts un-acked LOAD cycles; expired flags the last allowed cycle.
// Combinational expiry flag, so the controller can leave LOAD on the same edge.
module wb_load_timer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic CLK_WB,
    input  logic RESET_N,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is the TIMEOUT_CYC-th LOAD cycle; an ack in that same cycle still wins upstream.
    assign expired = active && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if (active && !ack && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: resolves ALU/LOAD/LINK data and drives a registered one-cycle
// register-file write strobe. WB_TIMEOUT_EN adds a load timeout with LOAD_ERR pulse.
module wb_ctrl
    import cpu15_wb_pkg::*;
#(
    parameter int DATA_W      = WB_DATA_W,
    parameter int RN_W        = WB_RN_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              CLK_WB,
    input  logic              RESET_N,
    input  logic              EX_VALID,
    output logic              EX_READY,
    input  logic [1:0]        EX_OP,
    input  logic [RN_W-1:0]   EX_DST,
    input  logic [DATA_W-1:0] EX_DATA,
    input  logic [DATA_W-1:0] EX_PC,
    output logic              MEM_REQ,
    output logic [DATA_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [RN_W-1:0]   N_REG,
    output logic [DATA_W-1:0] REG_IN,
    output logic              REG_WEN,
    output logic              BUSY,
    output logic              LOAD_ERR
);

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [RN_W-1:0]   n_reg_q, n_reg_d;
    logic [DATA_W-1:0] reg_in_q, reg_in_d;
    logic              ex_ready_q, ex_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              reg_wen_q, reg_wen_d;
    logic              busy_q, busy_d;
    logic              load_expired;
    logic              load_err_d;
    logic              accept;

`ifdef WB_TIMEOUT_EN
    logic load_err_q;

    wb_load_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_load_timer (
        .CLK_WB (CLK_WB),
        .RESET_N(RESET_N),
        .active (state_q == ST_LOAD),
        .ack    (MEM_ACK),
        .expired(load_expired)
    );

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign LOAD_ERR = load_err_q;
`else
    assign load_expired = 1'b0;
    assign LOAD_ERR     = 1'b0;
`endif

    assign accept = EX_VALID && ex_ready_q;

    always_comb begin
        state_d    = ST_IDLE;
        mem_addr_d = mem_addr_q;
        n_reg_d    = n_reg_q;
        reg_in_d   = reg_in_q;
        load_err_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (accept) begin
                    case (EX_OP)
                        WB_OP_ALU: begin
                            n_reg_d  = EX_DST;
                            reg_in_d = EX_DATA;
                            state_d  = ST_WRITE;
                        end
                        WB_OP_LINK: begin
                            n_reg_d  = EX_DST;
                            reg_in_d = EX_PC + DATA_W'(1);
                            state_d  = ST_WRITE;
                        end
                        WB_OP_LOAD: begin
                            n_reg_d    = EX_DST;
                            mem_addr_d = EX_DATA;
                            state_d    = ST_LOAD;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (MEM_ACK) begin
                    reg_in_d = MEM_RDATA;
                    state_d  = ST_WRITE;
                end else if (load_expired) begin
                    load_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ex_ready_d = (state_d != ST_LOAD);
        mem_req_d  = (state_d == ST_LOAD);
        busy_d     = (state_d == ST_LOAD);
        reg_wen_d  = (state_d == ST_WRITE);
    end

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            n_reg_q    <= '0;
            reg_in_q   <= '0;
            ex_ready_q <= 1'b0;
            mem_req_q  <= 1'b0;
            reg_wen_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            n_reg_q    <= n_reg_d;
            reg_in_q   <= reg_in_d;
            ex_ready_q <= ex_ready_d;
            mem_req_q  <= mem_req_d;
            reg_wen_q  <= reg_wen_d;
            busy_q     <= busy_d;
        end
    end

    assign EX_READY = ex_ready_q;
    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;
    assign N_REG    = n_reg_q;
    assign REG_IN   = reg_in_q;
    assign REG_WEN  = reg_wen_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: inputs driven and outputs sampled 1ns after each rising edge.
module tb_wb_ctrl;

    logic        CLK_WB = 1'b0;
    logic        RESET_N;
    logic        EX_VALID;
    logic        EX_READY;
    logic [1:0]  EX_OP;
    logic [2:0]  EX_DST;
    logic [15:0] EX_DATA;
    logic [15:0] EX_PC;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA;
    logic [2:0]  N_REG;
    logic [15:0] REG_IN;
    logic        REG_WEN;
    logic        BUSY;
    logic        LOAD_ERR;

    int checks   = 0;
    int failures = 0;

    wb_ctrl #(.DATA_W(16), .RN_W(3), .TIMEOUT_CYC(15)) dut (
        .CLK_WB   (CLK_WB),
        .RESET_N  (RESET_N),
        .EX_VALID (EX_VALID),
        .EX_READY (EX_READY),
        .EX_OP    (EX_OP),
        .EX_DST   (EX_DST),
        .EX_DATA  (EX_DATA),
        .EX_PC    (EX_PC),
        .MEM_REQ  (MEM_REQ),
        .MEM_ADDR (MEM_ADDR),
        .MEM_ACK  (MEM_ACK),
        .MEM_RDATA(MEM_RDATA),
        .N_REG    (N_REG),
        .REG_IN   (REG_IN),
        .REG_WEN  (REG_WEN),
        .BUSY     (BUSY),
        .LOAD_ERR (LOAD_ERR)
    );

    always #5 CLK_WB = ~CLK_WB;

    task automatic cyc();
        @(posedge CLK_WB);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic [2:0] dst,
                         input logic [15:0] dat, input logic [15:0] pc);
        EX_VALID = vld;
        EX_OP    = op;
        EX_DST   = dst;
        EX_DATA  = dat;
        EX_PC    = pc;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        MEM_ACK = 1'b0;
        MEM_RDATA = 16'h0;
        cyc();
        cyc();
        checks++;
        if ({EX_READY, MEM_REQ, MEM_ADDR, N_REG, REG_IN, REG_WEN, BUSY, LOAD_ERR} !== 39'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b req=%b addr=%h n=%0d in=%h wen=%b busy=%b err=%b want all 0",
                     EX_READY, MEM_REQ, MEM_ADDR, N_REG, REG_IN, REG_WEN, BUSY, LOAD_ERR);
        end
        RESET_N = 1'b1;
        cyc();
        checks++;
        if ({EX_READY, REG_WEN, MEM_REQ} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release got rdy/wen/req=%b want 100", {EX_READY, REG_WEN, MEM_REQ});
        end
    endtask

    task automatic test_alu_back_to_back();
        drive(1'b1, 2'b01, 3'd3, 16'h1234, 16'h0);
        cyc();
        drive(1'b1, 2'b01, 3'd5, 16'hABCD, 16'h0);
        checks++;
        if ({REG_WEN, N_REG, REG_IN} !== {1'b1, 3'd3, 16'h1234}) begin
            failures++;
            $display("FAIL alu_write1 got wen=%b n=%0d in=%h want 1,3,1234", REG_WEN, N_REG, REG_IN);
        end
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({REG_WEN, N_REG, REG_IN} !== {1'b1, 3'd5, 16'hABCD}) begin
            failures++;
            $display("FAIL alu_write2 got wen=%b n=%0d in=%h want 1,5,abcd", REG_WEN, N_REG, REG_IN);
        end
        cyc();
        checks++;
        if (REG_WEN !== 1'b0) begin
            failures++;
            $display("FAIL alu_wen_drop got wen=%b want 0", REG_WEN);
        end
    endtask

    task automatic test_link_wrap();
        drive(1'b1, 2'b11, 3'd7, 16'h5555, 16'hFFFF);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({REG_WEN, N_REG, REG_IN} !== {1'b1, 3'd7, 16'h0000}) begin
            failures++;
            $display("FAIL link_wrap got wen=%b n=%0d in=%h want 1,7,0000", REG_WEN, N_REG, REG_IN);
        end
        cyc();
        checks++;
        if (REG_WEN !== 1'b0) begin
            failures++;
            $display("FAIL link_single got wen=%b want 0", REG_WEN);
        end
    endtask

    task automatic test_load_wait();
        drive(1'b1, 2'b10, 3'd2, 16'h0040, 16'h0);
        cyc();
        // Execute keeps presenting a different instruction that must be ignored.
        drive(1'b1, 2'b01, 3'd6, 16'h9999, 16'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({MEM_REQ, MEM_ADDR, EX_READY, BUSY, REG_WEN} !== {1'b1, 16'h0040, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL load_wait%0d got req=%b addr=%h rdy=%b busy=%b wen=%b want 1,0040,0,1,0",
                         i, MEM_REQ, MEM_ADDR, EX_READY, BUSY, REG_WEN);
            end
            if (i == 2) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = 16'hBEEF;
            end
            cyc();
        end
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0;
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({REG_WEN, N_REG, REG_IN, MEM_REQ, EX_READY} !== {1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL load_write got wen=%b n=%0d in=%h req=%b rdy=%b want 1,2,beef,0,1",
                     REG_WEN, N_REG, REG_IN, MEM_REQ, EX_READY);
        end
        cyc();
        checks++;
        if (REG_WEN !== 1'b0) begin
            failures++;
            $display("FAIL load_single got wen=%b want 0", REG_WEN);
        end
    endtask

    task automatic test_nop_stray_ack();
        drive(1'b1, 2'b00, 3'd4, 16'h7777, 16'h0);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({REG_WEN, EX_READY, MEM_REQ} !== 3'b010) begin
            failures++;
            $display("FAIL nop got wen/rdy/req=%b want 010", {REG_WEN, EX_READY, MEM_REQ});
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = 16'hDEAD;
        cyc();
        MEM_ACK = 1'b0;
        checks++;
        if ({REG_WEN, MEM_REQ, BUSY, EX_READY, REG_IN} !== {4'b0001, 16'hBEEF}) begin
            failures++;
            $display("FAIL stray_ack got wen=%b req=%b busy=%b rdy=%b in=%h want 0,0,0,1,beef",
                     REG_WEN, MEM_REQ, BUSY, EX_READY, REG_IN);
        end
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, 2'b10, 3'd4, 16'h0080, 16'h0);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({MEM_REQ, MEM_ADDR} !== {1'b1, 16'h0080}) begin
            failures++;
            $display("FAIL rst_load_req got req=%b addr=%h want 1,0080", MEM_REQ, MEM_ADDR);
        end
        RESET_N   = 1'b0;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 16'h1111;
        cyc();
        cyc();
        checks++;
        if ({MEM_REQ, REG_WEN, BUSY, EX_READY, MEM_ADDR, N_REG, REG_IN} !== 39'h0) begin
            failures++;
            $display("FAIL rst_mid_load got req=%b wen=%b busy=%b rdy=%b addr=%h n=%0d in=%h want all 0",
                     MEM_REQ, REG_WEN, BUSY, EX_READY, MEM_ADDR, N_REG, REG_IN);
        end
        RESET_N = 1'b1;
        MEM_ACK = 1'b0;
        cyc();
        checks++;
        if ({EX_READY, REG_WEN, MEM_REQ, BUSY} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_release got rdy/wen/req/busy=%b want 1000",
                     {EX_READY, REG_WEN, MEM_REQ, BUSY});
        end
        cyc();
        checks++;
        if (REG_WEN !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard got wen=%b want 0", REG_WEN);
        end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        // Expiry without ack: 15 request cycles, then LOAD_ERR and no write.
        drive(1'b1, 2'b10, 3'd1, 16'h0100, 16'h0);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        for (int i = 0; i < 14; i++) cyc();
        checks++;
        if ({MEM_REQ, LOAD_ERR} !== 2'b10) begin
            failures++;
            $display("FAIL to_last_req got req/err=%b want 10", {MEM_REQ, LOAD_ERR});
        end
        cyc();
        checks++;
        if ({LOAD_ERR, REG_WEN, MEM_REQ, EX_READY} !== 4'b1001) begin
            failures++;
            $display("FAIL to_expire got err/wen/req/rdy=%b want 1001",
                     {LOAD_ERR, REG_WEN, MEM_REQ, EX_READY});
        end
        cyc();
        checks++;
        if ({LOAD_ERR, REG_WEN} !== 2'b00) begin
            failures++;
            $display("FAIL to_pulse got err/wen=%b want 00", {LOAD_ERR, REG_WEN});
        end
        // Ack on the expiry cycle wins.
        drive(1'b1, 2'b10, 3'd6, 16'h0200, 16'h0);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        for (int i = 0; i < 14; i++) cyc();
        MEM_ACK   = 1'b1;
        MEM_RDATA = 16'hCAFE;
        cyc();
        MEM_ACK = 1'b0;
        checks++;
        if ({LOAD_ERR, REG_WEN, N_REG, REG_IN} !== {1'b0, 1'b1, 3'd6, 16'hCAFE}) begin
            failures++;
            $display("FAIL to_ack_wins got err=%b wen=%b n=%0d in=%h want 0,1,6,cafe",
                     LOAD_ERR, REG_WEN, N_REG, REG_IN);
        end
        cyc();
    endtask
`else
    task automatic test_timeout();
        // Without the timeout a load waits indefinitely and LOAD_ERR never rises.
        drive(1'b1, 2'b10, 3'd1, 16'h0100, 16'h0);
        cyc();
        drive(1'b0, 2'b00, 3'd0, 16'h0, 16'h0);
        for (int i = 0; i < 20; i++) cyc();
        checks++;
        if ({MEM_REQ, LOAD_ERR, EX_READY} !== 3'b100) begin
            failures++;
            $display("FAIL no_to_wait got req/err/rdy=%b want 100", {MEM_REQ, LOAD_ERR, EX_READY});
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = 16'hCAFE;
        cyc();
        MEM_ACK = 1'b0;
        checks++;
        if ({LOAD_ERR, REG_WEN, N_REG, REG_IN} !== {1'b0, 1'b1, 3'd1, 16'hCAFE}) begin
            failures++;
            $display("FAIL no_to_write got err=%b wen=%b n=%0d in=%h want 0,1,1,cafe",
                     LOAD_ERR, REG_WEN, N_REG, REG_IN);
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_link_wrap();
        test_load_wait();
        test_nop_stray_ack();
        test_reset_mid_load();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
